// File: rtl/fcf_pkg.sv
// fcf_pkg: shared widths and FSM state constants for the FC vector feeder
package fcf_pkg;
   localparam int RES_W = 57;
   localparam int ACT_W = 8;
   localparam int WGT_W = 24;
   typedef logic [1:0] state_t;
   localparam state_t IDLE     = 2'd0;
   localparam state_t STREAM   = 2'd1;
   localparam state_t WAIT_RES = 2'd2;
   localparam state_t HOLD     = 2'd3;
endpackage

// File: rtl/fcf_addr_gen.sv
// fcf_addr_gen: activation/weight address generator with per-neuron pair counter
module fcf_addr_gen
   import fcf_pkg::*;
#(
   parameter int VEC_LEN = 16,
   parameter int AAW     = 8,
   parameter int WAW     = 12
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           restart,
   input  logic           step,
   input  logic [AAW-1:0] act_base,
   input  logic [WAW-1:0] wgt_base,
   output logic [AAW-1:0] act_addr,
   output logic [WAW-1:0] wgt_addr,
   output logic           first,
   output logic           last
);
   localparam int CW = $clog2(VEC_LEN);
   logic [AAW-1:0] latched_act;
   logic [CW-1:0]  cnt;
   assign first = cnt == '0;
   assign last  = cnt == CW'(VEC_LEN - 1);
   // activation address restarts per neuron; weight address runs on across neurons
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latched_act <= '0;
         act_addr    <= '0;
         wgt_addr    <= '0;
         cnt         <= '0;
      end else if (load) begin
         latched_act <= act_base;
         act_addr    <= act_base;
         wgt_addr    <= wgt_base;
         cnt         <= '0;
      end else if (restart) begin
         act_addr <= latched_act;
         cnt      <= '0;
      end else if (step) begin
         act_addr <= act_addr + 1'b1;
         wgt_addr <= wgt_addr + 1'b1;
         cnt      <= last ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/fc_vector_feeder.sv
// fc_vector_feeder: streams SRAM operand pairs to the FC core and captures results (FCF_TIMEOUT_EN adds a result timeout)
module fc_vector_feeder
   import fcf_pkg::*;
#(
   parameter int VEC_LEN = 16,
   parameter int AAW     = 8,
   parameter int WAW     = 12,
   parameter int TMO     = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AAW-1:0]   cmd_act_base,
   input  logic [WAW-1:0]   cmd_wgt_base,
   input  logic [15:0]      cmd_neurons,
   output logic             act_ren,
   output logic [AAW-1:0]   act_addr,
   input  logic [ACT_W-1:0] act_rdata,
   output logic             wgt_ren,
   output logic [WAW-1:0]   wgt_addr,
   input  logic [WGT_W-1:0] wgt_rdata,
   output logic [ACT_W-1:0] vec1,
   output logic [WGT_W-1:0] vec2,
   output logic             start,
   input  logic             o_valid,
   input  logic [RES_W-1:0] o,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic [15:0]      res_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);
   state_t      state;
   logic [15:0] neurons;
   logic [15:0] neuron;
   logic        accept;
   logic        step;
   logic        restart;
   logic        first;
   logic        last;
   logic        last_neuron;
   logic        timeout;
   logic        ren_d;
   logic        first_d;
   assign cmd_ready   = (state == IDLE) && !reset;
   assign accept      = cmd_valid && cmd_ready;
   assign busy        = state != IDLE;
   assign step        = state == STREAM;
   assign act_ren     = step;
   assign wgt_ren     = step;
   assign last_neuron = neuron == neurons - 16'd1;
   assign restart     = (state == HOLD) && res_ready && !last_neuron;
   fcf_addr_gen #(.VEC_LEN(VEC_LEN), .AAW(AAW), .WAW(WAW)) u_addr (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .restart  (restart),
      .step     (step),
      .act_base (cmd_act_base),
      .wgt_base (cmd_wgt_base),
      .act_addr (act_addr),
      .wgt_addr (wgt_addr),
      .first    (first),
      .last     (last)
   );
`ifdef FCF_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   assign timeout = (state == WAIT_RES) && !o_valid && (tmo_cnt == TW'(TMO - 1));
   // result-wait cycle counter and sticky error (timeout or result during streaming)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         tmo_cnt <= (state == WAIT_RES) ? tmo_cnt + 1'b1 : '0;
         err     <= err | timeout | ((state == STREAM) && o_valid);
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
   // command FSM, neuron bookkeeping and result register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         neurons   <= '0;
         neuron    <= '0;
         done      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               neurons <= cmd_neurons;
               neuron  <= '0;
               state   <= (cmd_neurons == 16'd0) ? IDLE : STREAM;
               done    <= cmd_neurons == 16'd0;
            end
            STREAM: if (last) state <= WAIT_RES;
            WAIT_RES: if (o_valid) begin
               res_data  <= o;
               res_idx   <= neuron;
               res_valid <= 1'b1;
               state     <= HOLD;
            end else if (timeout) begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= last_neuron ? IDLE : STREAM;
               done      <= last_neuron;
               neuron    <= last_neuron ? neuron : neuron + 16'd1;
            end
         endcase
      end
   end
   // two-stage operand path: SRAM latency then output register; start tags pair 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ren_d   <= 1'b0;
         first_d <= 1'b0;
         start   <= 1'b0;
         vec1    <= '0;
         vec2    <= '0;
      end else begin
         ren_d   <= step;
         first_d <= step && first;
         start   <= ren_d && first_d;
         vec1    <= ren_d ? act_rdata : vec1;
         vec2    <= ren_d ? wgt_rdata : vec2;
      end
   end
endmodule
